// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer width helper, read-mode names and the
// status flag bundle common to the single- and dual-clock FIFOs.
package fifo_pkg;

    localparam string FT_TRUE  = "TRUE";
    localparam string FT_FALSE = "FALSE";

    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic near_full;
        logic near_empty;
        logic over_flow;
        logic under_flow;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one
// combinational read port, shared by the single- and dual-clock FIFOs.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             i_clk,
    input  logic             i_wen,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact fill level, run-time near-full/near-empty
// margins, overflow/underflow pulses, a high-water mark and a selectable read mode.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wen,
    input  logic [DSIZE-1:0] wdata,
    input  logic             ren,
    input  logic [ASIZE:0]   near_full_mrgn,
    input  logic [ASIZE:0]   near_empty_mrgn,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             near_full,
    output logic             near_empty,
    output logic             over_flow,
    output logic             under_flow,
    output logic [ASIZE:0]   level,
    output logic [ASIZE:0]   max_level
);

    localparam int          PW          = ptr_width(ASIZE);
    localparam int          DEPTH       = 1 << ASIZE;
    localparam logic [PW-1:0] DEPTH_W   = PW'(DEPTH);
    localparam fifo_flags_t FLAGS_RESET = fifo_flags_t'(6'b010000);

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_level;
    logic [PW-1:0] r_max_level;
    fifo_flags_t   r_flags;

    logic          w_wacc;
    logic          w_racc;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] w_free_next;
    logic          w_full_next;
    logic          w_empty_next;
    fifo_flags_t   w_flags_next;
    logic [DSIZE-1:0] w_mem_rdata;

    // Acceptance is decided from the registered flags; clr blocks both sides.
    always_comb begin
        w_wacc       = wen && !r_flags.full  && !clr;
        w_racc       = ren && !r_flags.empty && !clr;
        w_level_next = r_level;
        if (clr) begin
            w_level_next = '0;
        end else if (w_wacc && !w_racc) begin
            w_level_next = r_level + PW'(1);
        end else if (!w_wacc && w_racc) begin
            w_level_next = r_level - PW'(1);
        end
        w_free_next  = DEPTH_W - w_level_next;
        w_full_next  = (w_level_next == DEPTH_W);
        w_empty_next = (w_level_next == '0);

        w_flags_next            = '0;
        w_flags_next.full       = w_full_next;
        w_flags_next.empty      = w_empty_next;
        w_flags_next.near_full  = !w_full_next  && (w_free_next  <= near_full_mrgn);
        w_flags_next.near_empty = !w_empty_next && (w_level_next <= near_empty_mrgn);
        w_flags_next.over_flow  = wen && r_flags.full  && !clr;
        w_flags_next.under_flow = ren && r_flags.empty && !clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_max_level <= '0;
            r_flags     <= FLAGS_RESET;
        end else begin
            r_level <= w_level_next;
            r_flags <= w_flags_next;
            if (clr) begin
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_max_level <= '0;
            end else begin
                if (w_wacc) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_racc) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_level_next > r_max_level) begin
                    r_max_level <= w_level_next;
                end
            end
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .i_clk   (clk),
        .i_wen   (w_wacc),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Fall-through exposes the head word directly; otherwise it is captured on each accepted read.
    if (FALLTHROUGH == FT_TRUE) begin : g_fallthrough
        assign rdata = w_mem_rdata;
    end else begin : g_registered
        logic [DSIZE-1:0] r_rdata;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rdata <= '0;
            end else if (w_racc) begin
                r_rdata <= w_mem_rdata;
            end
        end
        assign rdata = r_rdata;
    end

    assign full       = r_flags.full;
    assign empty      = r_flags.empty;
    assign near_full  = r_flags.near_full;
    assign near_empty = r_flags.near_empty;
    assign over_flow  = r_flags.over_flow;
    assign under_flow = r_flags.under_flow;
    assign level      = r_level;
    assign max_level  = r_max_level;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one fall-through and one registered-read
// instance driven by the same stimulus, checked against hand-computed values.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wen;
    logic       ren;
    logic [7:0] wdata;
    logic [4:0] nfMrgn;
    logic [4:0] neMrgn;

    logic [7:0] rdataFt,  rdataReg;
    logic       fullFt,   fullReg;
    logic       emptyFt,  emptyReg;
    logic       nfFt,     nfReg;
    logic       neFt,     neReg;
    logic       ofFt,     ofReg;
    logic       ufFt,     ufReg;
    logic [4:0] levelFt,  levelReg;
    logic [4:0] maxFt,    maxReg;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("TRUE")) dutFt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
        .near_full_mrgn(nfMrgn), .near_empty_mrgn(neMrgn),
        .rdata(rdataFt), .full(fullFt), .empty(emptyFt), .near_full(nfFt),
        .near_empty(neFt), .over_flow(ofFt), .under_flow(ufFt),
        .level(levelFt), .max_level(maxFt)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .FALLTHROUGH("FALSE")) dutReg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .wdata(wdata), .ren(ren),
        .near_full_mrgn(nfMrgn), .near_empty_mrgn(neMrgn),
        .rdata(rdataReg), .full(fullReg), .empty(emptyReg), .near_full(nfReg),
        .near_empty(neReg), .over_flow(ofReg), .under_flow(ufReg),
        .level(levelReg), .max_level(maxReg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Flags are packed as {full, empty, near_full, near_empty, over_flow, under_flow}.
    task automatic checkStatus(input string tag, input logic [4:0] lvl, input logic [5:0] flags);
        checkOutput({tag, " ft level"},  32'(levelFt),  32'(lvl));
        checkOutput({tag, " ft flags"},  32'({fullFt, emptyFt, nfFt, neFt, ofFt, ufFt}), 32'(flags));
        checkOutput({tag, " reg level"}, 32'(levelReg), 32'(lvl));
        checkOutput({tag, " reg flags"}, 32'({fullReg, emptyReg, nfReg, neReg, ofReg, ufReg}), 32'(flags));
    endtask

    task automatic checkMax(input string tag, input logic [4:0] lvl);
        checkOutput({tag, " ft max"},  32'(maxFt),  32'(lvl));
        checkOutput({tag, " reg max"}, 32'(maxReg), 32'(lvl));
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
        wen   = w;
        wdata = d;
        ren   = r;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic applyClear(input logic w);
        clr = 1'b1;
        wen = w;
        wdata = 8'hCC;
        @(posedge clk);
        #1;
        clr = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        wen    = 1'b0;
        ren    = 1'b0;
        wdata  = 8'h00;
        nfMrgn = 5'd4;
        neMrgn = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        checkStatus("reset", 5'd0, 6'b010000);
        checkMax("reset", 5'd0);
        checkOutput("reset reg rdata", 32'(rdataReg), 32'h00);

        // Read from empty
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkStatus("underflow", 5'd0, 6'b010001);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkStatus("underflow end", 5'd0, 6'b010000);

        // Fill to full, then one extra write
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
            if (i == 0) begin
                checkStatus("first write", 5'd1, 6'b000100);
                checkOutput("first word ft", 32'(rdataFt), 32'h10);
            end
            if (i == 14) checkStatus("level 15", 5'd15, 6'b001000);
        end
        checkStatus("full", 5'd16, 6'b100000);
        checkMax("full", 5'd16);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkStatus("overflow", 5'd16, 6'b100010);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkStatus("overflow end", 5'd16, 6'b100000);

        // Drain and compare order in both read modes
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain ft rdata", 32'(rdataFt), 32'(8'(8'h10 + i)));
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput("drain reg rdata", 32'(rdataReg), 32'(8'(8'h10 + i)));
        end
        checkStatus("drained", 5'd0, 6'b010000);
        checkMax("drained", 5'd16);

        // Simultaneous write and read while full
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
        checkStatus("refull", 5'd16, 6'b100000);
        applyStimulus(1'b1, 8'hDD, 1'b1);
        checkStatus("wr+rd full", 5'd15, 6'b001010);
        checkOutput("wr+rd full reg", 32'(rdataReg), 32'h80);
        checkOutput("wr+rd full ft", 32'(rdataFt), 32'h81);
        applyStimulus(1'b1, 8'h90, 1'b1);
        checkStatus("wr+rd mid", 5'd15, 6'b001000);
        checkOutput("wr+rd mid reg", 32'(rdataReg), 32'h81);
        checkOutput("wr+rd mid ft", 32'(rdataFt), 32'h82);

        // Simultaneous write and read while empty
        applyClear(1'b0);
        checkStatus("clear", 5'd0, 6'b010000);
        checkMax("clear", 5'd0);
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkStatus("wr+rd empty", 5'd1, 6'b000101);
        checkOutput("wr+rd empty ft", 32'(rdataFt), 32'h55);
        checkOutput("wr+rd empty reg", 32'(rdataReg), 32'h81);
        checkMax("wr+rd empty", 5'd1);
        applyClear(1'b0);

        // Near-empty margin
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0);
        checkStatus("ne lvl4", 5'd4, 6'b000100);
        neMrgn = 5'd6;
        applyStimulus(1'b1, 8'hA4, 1'b0);
        checkStatus("ne lvl5 m6", 5'd5, 6'b000100);
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkStatus("ne lvl6 m6", 5'd6, 6'b000100);
        applyStimulus(1'b1, 8'hA6, 1'b0);
        checkStatus("ne lvl7 m6", 5'd7, 6'b000000);

        // Near-full margin
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hA7 + i), 1'b0);
        checkStatus("nf lvl12", 5'd12, 6'b001000);
        nfMrgn = 5'd3;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkStatus("nf m3", 5'd12, 6'b000000);
        applyStimulus(1'b1, 8'hAC, 1'b0);
        checkStatus("nf lvl13", 5'd13, 6'b001000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hAD + i), 1'b0);
        checkStatus("nf lvl16", 5'd16, 6'b100000);
        checkMax("nf lvl16", 5'd16);

        // Oversized margin
        applyClear(1'b0);
        nfMrgn = 5'd31;
        applyStimulus(1'b1, 8'h01, 1'b0);
        checkStatus("big margin", 5'd1, 6'b001100);
        nfMrgn = 5'd4;

        // Clear mid-stream together with a write
        applyClear(1'b0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0);
        checkStatus("lvl9", 5'd9, 6'b000000);
        applyClear(1'b1);
        checkStatus("clr+wen", 5'd0, 6'b010000);
        checkMax("clr+wen", 5'd0);
        checkOutput("clr keeps reg rdata", 32'(rdataReg), 32'h81);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkStatus("after clr", 5'd0, 6'b010000);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkStatus("post clr write", 5'd1, 6'b000100);
        checkOutput("post clr ft", 32'(rdataFt), 32'h5A);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        checkStatus("lvl9 again", 5'd9, 6'b000000);
        wen   = 1'b1;
        wdata = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checkStatus("async reset", 5'd0, 6'b010000);
        checkMax("async reset", 5'd0);
        checkOutput("async reset reg rdata", 32'(rdataReg), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wen   = 1'b0;
        checkStatus("reset held", 5'd0, 6'b010000);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkStatus("after reset", 5'd0, 6'b010000);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        checkStatus("post reset write", 5'd1, 6'b000100);
        checkOutput("post reset ft", 32'(rdataFt), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO for data paths that do not cross clock domains. It keeps the flag set of the dual-clock FIFO (full, empty, run-time near-full/near-empty margins, overflow/underflow) and adds a selectable read mode, an exact fill-level output and a high-water mark. It sits between a producer and a consumer that share one clock, and it reuses the same memory sub-module as the dual-clock FIFO.

## Interface
- DSIZE, 8, word width in bits
- ASIZE, 4, address bits; DEPTH = 1<<ASIZE words
- FALLTHROUGH, "TRUE", "TRUE" = first-word fall-through (combinational rdata); any other value = registered read, 1-cycle latency
- clk  input  1  single clock; all state changes on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of pointers, level, flags and watermark
- wen  input  1  write request
- wdata  input  DSIZE  write data
- ren  input  1  read request
- near_full_mrgn  input  ASIZE+1  near-full margin in free words
- near_empty_mrgn  input  ASIZE+1  near-empty margin in stored words
- rdata  output  DSIZE  read data
- full, empty, near_full, near_empty  output  1 each  status flags
- over_flow, under_flow  output  1 each  one-cycle error pulses
- level  output  ASIZE+1  stored word count, 0..DEPTH
- max_level  output  ASIZE+1  highest level since reset or clr

## Operation
- Write and read pointers are ASIZE+1 bits wide, binary, with an MSB wrap bit. Both wrap modulo 2·DEPTH.
- A write is accepted when wen=1 and full=0. Memory is written at wptr[ASIZE-1:0], then wptr increments.
- A read is accepted when ren=1 and empty=0. rptr increments.
- Acceptance uses the registered flags of the current cycle.
  - wen and ren together while full: the read is accepted, the write is dropped, and over_flow pulses.
  - wen and ren together while empty: the write is accepted, the read is dropped, and under_flow pulses.
  - Otherwise both are accepted and level is unchanged.
- level_next = level + write_accepted − read_accepted.
- full = (level == DEPTH). empty = (level == 0).
- near_full = !full && (DEPTH − level) <= near_full_mrgn. It is 0 while full.
- near_empty = !empty && level <= near_empty_mrgn. It is 0 while empty.
- Flags are registered from level_next and the current margin inputs. A margin change therefore takes effect at the next rising edge.
- Margin arithmetic is unsigned and ASIZE+1 bits wide. A margin >= DEPTH holds the near flag whenever the FIFO is neither full nor empty.
- over_flow = 1 for the cycle after a dropped write. under_flow = 1 for the cycle after a dropped read.
- max_level is updated to level_next when level_next > max_level.
- FALLTHROUGH "TRUE": rdata = mem[rptr] combinationally. It is valid whenever empty=0 and advances in the same cycle as an accepted read.
- FALLTHROUGH other: rdata is a register loaded with mem[rptr] on an accepted read. It holds its value otherwise.
- clr has priority over wen and ren.
  - The cycle in which clr=1 at an edge accepts no write or read.
  - At that edge the pointers, level and max_level go to 0, empty goes to 1, and all other flags go to 0.
  - No error pulse is generated for that cycle.
  - clr does not modify memory contents or rdata.

## Timing
- Reset values while rst_n=0:
  - pointers, level, max_level = 0
  - empty = 1
  - full, near_full, near_empty, over_flow, under_flow = 0
  - rdata register = 0
- Reset assertion takes effect immediately. In-flight requests are discarded, with no error pulse.
- The first write is visible one edge after it is accepted:
  - empty falls
  - level = 1
  - in fall-through mode, rdata shows the word
- Registered-read latency: rdata is valid 1 cycle after the accepting edge.
- Flag latency: every flag and level reflects the edge at which a request is accepted, with no extra delay. This improves on the 2-cycle synchroniser latency of the dual-clock FIFO.
- Writing DEPTH words back-to-back with no reads: full rises at the edge that accepts the DEPTH-th write.

## Structure
- Shared package fifo_pkg:
  - localparam helper function for pointer width (ASIZE+1)
  - mode constants FT_TRUE / FT_FALSE
  - flag-struct typedef (full, empty, near_full, near_empty, over_flow, under_flow), also used by the dual-clock FIFO
- Sub-module fifo_mem:
  - DSIZE×DEPTH register array with one synchronous write port and one combinational read port
  - the same module the dual-clock FIFO instantiates
- Top-level sync_fifo contains:
  - pointer, level and flag logic
  - watermark register
  - a generate branch for the read mode

## Test plan
- Reset, then ren=1 for one cycle -> empty=1 throughout, under_flow=1 for exactly one cycle, level=0.
- Write 16 random words (DEPTH=16), then wen=1 once more -> full=1 at the 16th edge, over_flow one-cycle pulse, level=16, max_level=16. Then read 16 -> data matches write order in both FALLTHROUGH modes (registered mode checked 1 cycle later), empty=1.
- Fill to 16, then wen=1 and ren=1 for one cycle -> read accepted, write dropped, over_flow=1, level=15.
- Margins 4/4: write 4 -> near_empty=1. Set near_empty_mrgn=6, write 2 -> near_empty=1. Write 1 more (level 7) -> near_empty=0.
- Full-side margins: write to level 12 -> near_full=1. Set near_full_mrgn=3 -> near_full=0 next edge. Write 1 (level 13) -> near_full=1. Write 3 (level 16) -> near_full=0, full=1.
- Clear and asynchronous reset mid-stream:
  - at level 9, assert clr together with wen=1 -> next edge level=0, empty=1, max_level=0, no pulse
  - repeat with rst_n asserted mid-cycle -> outputs go to reset values immediately
